// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: word width, the NOP encoding,
// fetch FSM state codes and the IF/ID pipeline bundle.
package mips_pkg;

    localparam int WORD_W = 32;

    // sll $0,$0,0
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

    // Fetch FSM states, kept as plain 2-bit codes for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_BOOT   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_HALTED = 2'd2;

    // IF/ID register contents; the ID stage consumes the same bundle.
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus4;
        logic              valid;
        logic              fault;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush (load bubble) and hold controls.
// Flush wins over hold so a squash is never lost behind a stall.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t bubble;

    assign bubble = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0, fault: 1'b0};

    // Register stage: reset/flush to a bubble, otherwise load unless held.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            q <= bubble;
        end else if (flush) begin
            q <= bubble;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address, and fills the IF/ID register. Handles stall, redirect,
// halt/resume and flags out-of-range or misaligned fetches.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 256,
    parameter logic [31:0] NOP_WORD  = mips_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] RedAddress,
    input  logic [31:0] instruction_mem,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic        halted
);

    import mips_pkg::*;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    state_t      state;
    state_t      state_next;
    logic        fault;
    logic        ifid_hold;
    logic        ifid_flush;
    if_id_t      ifid_d;
    if_id_t      ifid_q;

    assign pc_plus4 = pc + 32'd4;
    assign target   = redirect_pc & ~32'd3;
    assign fault    = (pc[1:0] != 2'b00) || (pc > LAST_WORD);

    assign ifid_d = '{instr:    fault ? NOP_WORD : instruction_mem,
                      pc_plus4: pc_plus4,
                      valid:    1'b1,
                      fault:    fault};

    // Next PC, next state and IF/ID controls from the current state and requests.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        pc_next    = pc;
        state_next = state;
        ifid_hold  = 1'b1;
        ifid_flush = 1'b0;
        case (state)
            ST_BOOT: begin
                state_next = ST_RUN;
                if (redirect) pc_next = target;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_next    = target;
                    ifid_flush = 1'b1;
                end else if (halt_req) begin
                    ifid_flush = 1'b1;
                    state_next = ST_HALTED;
                end else if (!stall) begin
                    ifid_hold = 1'b0;
                    pc_next   = pc_plus4;
                end
            end
            ST_HALTED: begin
                ifid_flush = 1'b1;
                if (redirect) pc_next = target;
                if (resume && !halt_req) state_next = ST_RUN;
            end
            default: state_next = ST_BOOT;
        endcase
    end

    // PC and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            state <= ST_BOOT;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_WORD)
    ) u_if_id_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .hold (ifid_hold),
        .flush(ifid_flush),
        .d    (ifid_d),
        .q    (ifid_q)
    );

    assign RedAddress     = pc;
    assign if_id_instr    = ifid_q.instr;
    assign if_id_pc_plus4 = ifid_q.pc_plus4;
    assign if_id_valid    = ifid_q.valid;
    assign fetch_fault    = ifid_q.fault;
    assign halted         = (state == ST_HALTED);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by a
// randomized phase, all compared against a behavioural fetch model.
module tb_if_fetch_unit;

    localparam int          MEM_BYTES = 256;
    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] OOR_WORD  = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] red_address;
    logic [31:0] instruction_mem;
    logic        stall, redirect, halt_req, resume;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        if_id_valid, fetch_fault, halted;

    int checks = 0;
    int errors = 0;

    // Byte-wide ROM image; words are assembled big-endian.
    logic [7:0] rom [MEM_BYTES];

    // Behavioural model: mode 0 = boot, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] e_instr, e_pp4;
    logic        e_valid, e_fault;

    if_fetch_unit #(
        .RESET_PC (32'h0),
        .MEM_BYTES(MEM_BYTES),
        .NOP_WORD (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RedAddress     (red_address),
        .instruction_mem(instruction_mem),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .resume         (resume),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_fault    (fetch_fault),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a <= 32'(MEM_BYTES - 4) && a[1:0] == 2'b00)
            return {rom[a[7:0]], rom[a[7:0] + 8'd1], rom[a[7:0] + 8'd2], rom[a[7:0] + 8'd3]};
        return OOR_WORD;
    endfunction

    // Zero-latency memory read.
    always_comb instruction_mem = word_at(red_address);

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'h0;
        e_instr = NOP;
        e_pp4   = 32'h0;
        e_valid = 1'b0;
        e_fault = 1'b0;
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_edge();
        logic        bad;
        logic [31:0] tgt;
        bad = (m_pc[1:0] != 2'b00) || (m_pc > 32'(MEM_BYTES - 4));
        tgt = {redirect_pc[31:2], 2'b00};
        if (m_mode == 0) begin
            if (redirect) m_pc = tgt;
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (redirect) begin
                m_pc = tgt;
                e_instr = NOP; e_valid = 1'b0; e_fault = 1'b0;
            end else if (halt_req) begin
                e_instr = NOP; e_valid = 1'b0; e_fault = 1'b0;
                m_mode = 2;
            end else if (!stall) begin
                e_instr = bad ? NOP : word_at(m_pc);
                e_pp4   = m_pc + 32'd4;
                e_valid = 1'b1;
                e_fault = bad;
                m_pc    = m_pc + 32'd4;
            end
        end else begin
            e_instr = NOP; e_valid = 1'b0; e_fault = 1'b0;
            if (redirect) m_pc = tgt;
            if (resume && !halt_req) m_mode = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        check32({tag, ".pc"},     red_address,          m_pc);
        check32({tag, ".instr"},  if_id_instr,          e_instr);
        check32({tag, ".valid"},  32'(if_id_valid),     32'(e_valid));
        check32({tag, ".fault"},  32'(fetch_fault),     32'(e_fault));
        check32({tag, ".halted"}, 32'(halted),          32'(m_mode == 2));
        if (e_valid) check32({tag, ".pp4"}, if_id_pc_plus4, e_pp4);
    endtask

    // One clock: inputs are already set; sample 1 ns after the edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        halt_req = 1'b0; resume = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) rom[i] = 8'($urandom);
        {rom[0], rom[1], rom[2], rom[3]} = 32'h2008_0005;
        {rom[4], rom[5], rom[6], rom[7]} = 32'h2009_0007;

        // Reset state.
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        check32("reset.pp4", if_id_pc_plus4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Boot cycle, then the first two fetches.
        step("boot");
        check32("boot.valid0", 32'(if_id_valid), 32'h0);
        step("fetch0");
        check32("fetch0.word", if_id_instr, 32'h2008_0005);
        check32("fetch0.pp4", if_id_pc_plus4, 32'h4);
        step("fetch4");
        check32("fetch4.word", if_id_instr, 32'h2009_0007);
        check32("fetch4.pp4", if_id_pc_plus4, 32'h8);

        // Three stalled edges at PC=8, then release.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            check32("stall.pc8", red_address, 32'h8);
            check32("stall.hold", if_id_instr, 32'h2009_0007);
        end
        stall = 1'b0;
        step("stall_release");

        // Redirect overrides stall; target bits [1:0] dropped.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0042;
        step("redir");
        check32("redir.pc40", red_address, 32'h40);
        idle_inputs();
        step("redir_fetch");

        // Last legal word, then first out-of-range word.
        redirect = 1'b1; redirect_pc = 32'hFC;
        step("to_fc");
        idle_inputs();
        step("fetch_fc");
        check32("fetch_fc.fault", 32'(fetch_fault), 32'h0);
        step("fetch_100");
        check32("fetch_100.fault", 32'(fetch_fault), 32'h1);
        check32("fetch_100.nop", if_id_instr, NOP);

        // Halt at 0x10, redirect while halted, resume.
        redirect = 1'b1; redirect_pc = 32'h10;
        step("to_10");
        idle_inputs();
        halt_req = 1'b1;
        step("halt");
        check32("halt.halted", 32'(halted), 32'h1);
        halt_req = 1'b0;
        step("halt_idle");
        redirect = 1'b1; redirect_pc = 32'h20;
        step("halt_redir");
        check32("halt_redir.pc", red_address, 32'h20);
        idle_inputs();
        resume = 1'b1;
        step("resume");
        resume = 1'b0;
        step("resume_fetch");
        check32("resume_fetch.pp4", if_id_pc_plus4, 32'h24);

        // Wrap-around of PC arithmetic at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step("to_top");
        idle_inputs();
        step("wrap");
        check32("wrap.pc0", red_address, 32'h0);

        // Async reset mid-cycle while halted and stalled.
        halt_req = 1'b1;
        step("halt2");
        halt_req = 1'b0; stall = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        step("reboot");

        // Randomized phase.
        for (int n = 0; n < 500; n++) begin
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            halt_req = ($urandom_range(0, 19) == 0);
            resume   = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       redirect_pc = $urandom;
                default: redirect_pc = 32'($urandom_range(0, 300));
            endcase
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage for the MIPS datapath. It is the initiator side of the instruction-memory read interface: it owns the program counter and drives the byte address to Memoriainstrucciones. It receives back the big-endian 32-bit word and registers it, together with PC+4, into the IF/ID pipeline register. It handles stall, branch/jump redirect, halt/resume, and out-of-range fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_BYTES, 256, size of the instruction ROM in bytes; the last legal word address is MEM_BYTES-4.
NOP_WORD, 32'h0000_0000, instruction word injected on flush, halt or fault (sll $0,$0,0).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
RedAddress  out  32  byte address to instruction memory; equals current PC (combinational from the PC register).
instruction_mem  in  32  word returned by memory for RedAddress, same cycle (zero-latency combinational read).
stall  in  1  hazard unit: hold PC and IF/ID.
redirect  in  1  branch taken or jump resolved in ID/EX.
redirect_pc  in  32  target byte address for redirect.
halt_req  in  1  request to stop fetching.
resume  in  1  leave HALTED.
if_id_instr  out  32  registered instruction.
if_id_pc_plus4  out  32  registered PC+4 of that instruction.
if_id_valid  out  1  IF/ID holds a real instruction.
fetch_fault  out  1  registered; the IF/ID entry came from an out-of-range or misaligned PC.
halted  out  1  FSM is in HALTED.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC.
  - if_id_instr=NOP_WORD, if_id_pc_plus4=0, if_id_valid=0, fetch_fault=0.
  - state=BOOT, halted=0.
- FSM states:
  - BOOT: one cycle; PC is presented but IF/ID is not loaded and valid stays 0. Next state is RUN. In BOOT, redirect still updates pc.
  - RUN: normal fetch.
  - HALTED: pc frozen; IF/ID loads NOP_WORD with valid=0; halted=1.
- Transitions:
  - RUN→HALTED when halt_req=1.
  - HALTED→RUN when resume=1 and halt_req=0.
  - While HALTED, a redirect updates pc but the FSM stays HALTED.
- RUN, per rising edge, priority high to low:
  1. redirect=1: pc<=redirect_pc with bits[1:0] forced to 0. IF/ID<=NOP_WORD, valid=0, fault=0. This squashes the wrong-path word. Redirect overrides stall.
  2. halt_req=1: pc holds; IF/ID<=NOP, valid=0; go to HALTED.
  3. stall=1: pc and all IF/ID outputs hold their values.
  4. otherwise: IF/ID<=(fault ? NOP_WORD : instruction_mem), if_id_pc_plus4<=pc+4, valid=1, fetch_fault<=fault; then pc<=pc+4.
- Fault condition (combinational): pc[1:0]!=0 or pc>MEM_BYTES-4. On a fault, PC still advances. The fault is a flag only; no trap is taken.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. RedAddress is never masked.
- Latency: the word at PC appears on if_id_instr one edge after PC is presented, absent stall or redirect.
- Reset mid-stall or mid-halt: asynchronous clear to the reset values above, regardless of state.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_WORD.
  - the FSM state enum (BOOT, RUN, HALTED, 2-bit).
  - WORD_W=32.
  - the IF/ID bundle typedef {instr, pc_plus4, valid, fault}, reused by the ID stage.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with hold/flush controls, reusable for the other stage registers.
- PC logic and FSM stay in the top module.

Test Plan:
- Reset then release, with memory preloaded words 0x20080005 at byte 0 and 0x20090007 at byte 4. BOOT cycle: valid=0 and RedAddress=0. Next edge: if_id_instr=0x20080005, pc_plus4=4, valid=1. Following edge: 0x20090007, pc_plus4=8.
- stall=1 for 3 cycles with PC=8. RedAddress stays 8 and the IF/ID contents stay unchanged for all 3 edges. After release, the next edge loads the word at byte 8.
- redirect=1 and stall=1 together, redirect_pc=0x0000_0042. pc becomes 0x40, if_id_valid=0, if_id_instr=0. Next edge fetches the word at 0x40.
- PC reaches 0xFC then advances to 0x100 with MEM_BYTES=256. The entry from 0xFC is valid with fault=0. The entry from 0x100 has instr=NOP, valid=1, fetch_fault=1.
- halt_req pulse at PC=0x10. halted=1, RedAddress stays 0x10, valid=0. A redirect to 0x20 while halted moves pc to 0x20 and the FSM stays HALTED. resume fetches 0x20 on the next edge.
- rst_n asserted low mid-cycle while HALTED with stall=1. Outputs clear immediately, without waiting for a clock edge, to pc=0, valid=0, halted=0, and the FSM re-enters BOOT.
